// File: rtl/tdm_demultiplexer_pkg.sv
// Shared constants and types for the TDM receive-side demultiplexer.
// Lane count, strobe width and the collect-FSM state encoding live here.
package tdm_demultiplexer_pkg;

  localparam int LANES    = 4;
  localparam int STROBE_W = LANES;
  localparam int SEL_W    = $clog2(LANES);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_COLLECT = 1'b1;

  typedef enum logic {
    S_IDLE    = ST_IDLE,
    S_COLLECT = ST_COLLECT
  } state_t;

endpackage

// File: rtl/tdm_demultiplexer_lane_decoder.sv
// Combinational 2-to-4 one-hot lane decoder with enable; zero latency.
// Output is all-zero whenever en is low.
module tdm_demultiplexer_lane_decoder
  import tdm_demultiplexer_pkg::*;
(
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  output logic [STROBE_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demultiplexer.sv
// Four-lane demultiplexer: addressed per-beat routing or sync-framed TDM collection.
// All outputs registered, one cycle after the sampling edge; no backpressure.
module tdm_demultiplexer
  import tdm_demultiplexer_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic                address0,
  input  logic                address1,
  input  logic [WIDTH-1:0]    in,
  input  logic                in_valid,
  input  logic                frame_sync,
  output logic [WIDTH-1:0]    out0,
  output logic [WIDTH-1:0]    out1,
  output logic [WIDTH-1:0]    out2,
  output logic [WIDTH-1:0]    out3,
  output logic [STROBE_W-1:0] lane_strobe,
  output logic                word_valid,
  output logic                frame_error
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             mode_q;
  logic             mode_change;

  logic [WIDTH-1:0] shadow_q [LANES-1];
  logic [WIDTH-1:0] lane_q   [LANES];

  logic                addr_en;
  logic                tdm_en;
  logic [SEL_W-1:0]    tdm_sel;
  logic [STROBE_W-1:0] addr_oh;
  logic [STROBE_W-1:0] tdm_oh;
  logic                frame_done;
  logic                sync_err;
  logic [STROBE_W-1:0] strobe_d;

  assign mode_change = mode ^ mode_q;
  assign addr_en     = ~mode & in_valid;

  // A TDM beat is only acted on when the mode is stable, and in IDLE only a
  // sync beat counts; switching into TDM therefore always waits for a sync.
  assign tdm_en  = mode & ~mode_change & in_valid
                 & (frame_sync | (state_q == S_COLLECT));
  assign tdm_sel = frame_sync ? '0 : cnt_q;

  tdm_demultiplexer_lane_decoder u_addr_dec (
    .en     (addr_en),
    .sel    ({address1, address0}),
    .onehot (addr_oh)
  );

  // Bits 0..2 enable the shadow registers; bit 3 is the lane-3 beat, which
  // completes the frame instead of being shadowed.
  tdm_demultiplexer_lane_decoder u_tdm_dec (
    .en     (tdm_en),
    .sel    (tdm_sel),
    .onehot (tdm_oh)
  );

  assign frame_done = tdm_oh[LANES-1];
  assign sync_err   = tdm_en & frame_sync & (state_q == S_COLLECT);
  assign strobe_d   = addr_oh | {STROBE_W{frame_done}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mode || mode_change) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (tdm_en) begin
      if (frame_sync) begin
        state_d = S_COLLECT;
        cnt_d   = SEL_W'(1);
      end else if (cnt_q == SEL_W'(LANES-1)) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      lane_strobe <= '0;
      word_valid  <= 1'b0;
      frame_error <= 1'b0;
      for (int i = 0; i < LANES-1; i++) begin
        shadow_q[i] <= '0;
      end
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode;
      lane_strobe <= strobe_d;
      word_valid  <= frame_done;
      frame_error <= sync_err;
      for (int i = 0; i < LANES-1; i++) begin
        if (tdm_oh[i]) begin
          shadow_q[i] <= in;
        end
      end
      for (int i = 0; i < LANES; i++) begin
        if (addr_oh[i]) begin
          lane_q[i] <= in;
        end
      end
      if (frame_done) begin
        for (int i = 0; i < LANES-1; i++) begin
          lane_q[i] <= shadow_q[i];
        end
        lane_q[LANES-1] <= in;
      end
    end
  end

  assign out0 = lane_q[0];
  assign out1 = lane_q[1];
  assign out2 = lane_q[2];
  assign out3 = lane_q[3];

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Bench for tdm_demultiplexer: directed scenarios plus random traffic
// compared against a frame-queue reference model.
module tb_tdm_demultiplexer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic         address0;
  logic         address1;
  logic [W-1:0] in;
  logic         in_valid;
  logic         frame_sync;
  logic [W-1:0] out0, out1, out2, out3;
  logic [3:0]   lane_strobe;
  logic         word_valid;
  logic         frame_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] m_out [4];
  logic [3:0]   m_strobe;
  logic         m_wv, m_fe;
  bit           m_mode_prev;
  bit           m_collect;
  logic [W-1:0] m_frame [$];

  always #5 clk = ~clk;

  tdm_demultiplexer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .address0    (address0),
    .address1    (address1),
    .in          (in),
    .in_valid    (in_valid),
    .frame_sync  (frame_sync),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .lane_strobe (lane_strobe),
    .word_valid  (word_valid),
    .frame_error (frame_error)
  );

  function automatic void model_update(bit r, bit md, bit [1:0] a, bit v, bit s, logic [W-1:0] d);
    bit changed;
    if (r) begin
      for (int i = 0; i < 4; i++) m_out[i] = '0;
      m_strobe = '0; m_wv = 0; m_fe = 0;
      m_mode_prev = 0; m_collect = 0; m_frame.delete();
      return;
    end
    m_strobe = '0; m_wv = 0; m_fe = 0;
    changed = (md != m_mode_prev);
    m_mode_prev = md;
    if (changed || !md) begin
      m_collect = 0;
      m_frame.delete();
    end
    if (!md) begin
      if (v) begin
        m_out[a] = d;
        m_strobe = 4'(1) << a;
      end
    end else if (!changed && v) begin
      if (s) begin
        if (m_collect) m_fe = 1;
        m_frame.delete();
        m_frame.push_back(d);
        m_collect = 1;
      end else if (m_collect) begin
        m_frame.push_back(d);
        if (m_frame.size() == 4) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
          m_strobe = 4'hF;
          m_wv = 1;
          m_frame.delete();
          m_collect = 0;
        end
      end
    end
  endfunction

  function automatic logic [4*W+5:0] exp_vec();
    return {m_out[3], m_out[2], m_out[1], m_out[0], m_strobe, m_wv, m_fe};
  endfunction

  function automatic logic [4*W+5:0] obs_vec();
    return {out3, out2, out1, out0, lane_strobe, word_valid, frame_error};
  endfunction

  task automatic step(input bit r, input bit md, input bit [1:0] a, input bit v,
                      input bit s, input logic [W-1:0] d);
    reset = r; mode = md; {address1, address0} = a;
    in_valid = v; frame_sync = s; in = d;
    @(posedge clk);
    model_update(r, md, a, v, s, d);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 2'(i), 1, 1, W'(1));
      n_checks++;
      if (obs_vec() !== '0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %h required 0", i, obs_vec());
      end
    end
  endtask

  task automatic test_addressed();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 2'(i), 1, 0, W'(1));
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL addressed lane %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      n_checks++;
      if (lane_strobe !== (4'(1) << i)) begin
        n_fail++;
        $display("FAIL addressed strobe %0d: got %b required %b", i, lane_strobe, 4'(1) << i);
      end
    end
    step(0, 0, 2'd0, 0, 0, W'(0));
    n_checks++;
    if (lane_strobe !== 4'b0000 || {out3, out2, out1, out0} !== {W'(1), W'(1), W'(1), W'(1)}) begin
      n_fail++;
      $display("FAIL addressed idle: got strobe %b outs %h required 0000 all-ones lanes",
               lane_strobe, {out3, out2, out1, out0});
    end
  endtask

  task automatic test_tdm_frame();
    logic [W-1:0] d [4] = '{W'(1), W'(0), W'(1), W'(1)};
    step(0, 1, 2'd0, 0, 0, W'(0));
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2'd0, 1, (i == 0), d[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL tdm_frame beat %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({out3, out2, out1, out0, lane_strobe, word_valid} !==
        {W'(1), W'(1), W'(0), W'(1), 4'hF, 1'b1}) begin
      n_fail++;
      $display("FAIL tdm_frame word: got %h %h %h %h strobe %b wv %b required 1 1 0 1 / 1111 / 1",
               out3, out2, out1, out0, lane_strobe, word_valid);
    end
    step(0, 1, 2'd0, 0, 0, W'(0));
    n_checks++;
    if (word_valid !== 1'b0 || lane_strobe !== 4'b0) begin
      n_fail++;
      $display("FAIL tdm_frame pulse: got wv %b strobe %b required 0 0000", word_valid, lane_strobe);
    end
  endtask

  task automatic test_premature_sync();
    bit           s [6] = '{1, 0, 1, 0, 0, 0};
    logic [W-1:0] d [6] = '{W'(1), W'(0), W'(0), W'(1), W'(1), W'(0)};
    int wv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 2'd0, 1, s[i], d[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL premature beat %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      if (i == 2) begin
        n_checks++;
        if (frame_error !== 1'b1) begin
          n_fail++;
          $display("FAIL premature error: got %b required 1", frame_error);
        end
      end
      if (i < 5 && word_valid === 1'b1) wv_seen++;
    end
    n_checks++;
    if ({out3, out2, out1, out0, word_valid} !== {W'(0), W'(1), W'(1), W'(0), 1'b1} || wv_seen != 0) begin
      n_fail++;
      $display("FAIL premature word: got %h %h %h %h wv %b early %0d required 0 1 1 0 wv 1 early 0",
               out3, out2, out1, out0, word_valid, wv_seen);
    end
  endtask

  task automatic test_gaps();
    bit           v [8] = '{1, 1, 1, 1, 0, 0, 1, 1};
    bit           s [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    logic [W-1:0] d [8] = '{W'(1), W'(1), W'(0), W'(1), W'(1), W'(1), W'(0), W'(1)};
    int wv_cnt = 0, fe_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 2'd3, v[i], s[i], d[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL gaps beat %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      wv_cnt += int'(word_valid);
      fe_cnt += int'(frame_error);
    end
    n_checks++;
    if ({out3, out2, out1, out0} !== {W'(1), W'(0), W'(1), W'(0)} || wv_cnt != 1 || fe_cnt != 0) begin
      n_fail++;
      $display("FAIL gaps word: got %h %h %h %h wv %0d fe %0d required 1 0 1 0 wv 1 fe 0",
               out3, out2, out1, out0, wv_cnt, fe_cnt);
    end
  endtask

  task automatic test_mode_change();
    int wv_cnt = 0;
    step(0, 1, 2'd0, 1, 1, W'(0));
    step(0, 1, 2'd0, 1, 0, W'(0));
    step(0, 0, 2'd2, 1, 0, W'(1));
    n_checks++;
    if (out2 !== W'(1) || lane_strobe !== 4'b0100 || word_valid !== 1'b0 || frame_error !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_change addr: got out2 %h strobe %b wv %b fe %b required 1 0100 0 0",
               out2, lane_strobe, word_valid, frame_error);
    end
    step(0, 1, 2'd0, 0, 0, W'(0));
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 2'd0, 1, (i == 4), W'(i & 1));
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL mode_change beat %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      wv_cnt += int'(word_valid);
    end
    n_checks++;
    if (wv_cnt != 1 || word_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mode_change resync: got wv count %0d last %b required 1 1", wv_cnt, word_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) begin
        step(0, 1, 2'd0, 1, (i == 0), W'($urandom));
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL back_to_back f%0d b%0d: got %h required %h", f, i, obs_vec(), exp_vec());
        end
      end
      n_checks++;
      if (word_valid !== 1'b1 || frame_error !== 1'b0) begin
        n_fail++;
        $display("FAIL back_to_back frame %0d: got wv %b fe %b required 1 0", f, word_valid, frame_error);
      end
    end
  endtask

  task automatic test_random();
    bit md = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) md = ~md;
      step(($urandom_range(79) == 0), md, 2'($urandom), ($urandom_range(3) != 0),
           ($urandom_range(4) == 0), W'($urandom));
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1; mode = 0; address0 = 0; address1 = 0;
    in = '0; in_valid = 0; frame_sync = 0;
    test_reset();
    test_addressed();
    test_tdm_frame();
    test_premature_sync();
    test_gaps();
    test_mode_change();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
